// File: rtl/key_sequence_controller.sv
// Key front-end for the switch/key adder: synchronises and debounces three active-low keys,
// enforces the A -> B -> ADD entry order, latches operands, forms the sum and flags illegal presses.
module key_sequence_controller #(
   parameter int unsigned W               = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned ERR_CYCLES      = 25000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_switch,
   input  logic         key0,
   input  logic         key1,
   input  logic         key2,
   output logic [W:0]   o_LED,
   output logic [1:0]   o_state,
   output logic         o_err
);

   localparam int unsigned LW  = W + 1;
   localparam int unsigned NK  = 3;
   localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned ERW = $clog2(ERR_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HAVE_A = 2'd1,
      ST_HAVE_B = 2'd2,
      ST_SHOW   = 2'd3
   } state_t;

   logic [NK-1:0]          sync1_q, sync1_d;
   logic [NK-1:0]          sync2_q, sync2_d;
   logic [NK-1:0]          deb_q, deb_d;
   logic [NK-1:0]          deb_prev_q, deb_prev_d;
   logic [NK-1:0]          armed_q, armed_d;
   logic [NK-1:0]          ev_q, ev_d;
   logic [NK-1:0][DBW-1:0] cnt_q, cnt_d;
   logic [1:0]             vld_q, vld_d;

   state_t                 state_q, state_d;
   logic [W-1:0]           a_q, a_d;
   logic [W-1:0]           b_q, b_d;
   logic [LW-1:0]          led_q, led_d;
   logic                   err_q, err_d;
   logic [ERW-1:0]         ecnt_q, ecnt_d;
   logic                   illegal;

   // Input conditioning; a key only becomes armed once it has been seen released after reset,
   // so a key held through reset cannot generate a press event.
   always_comb begin
      sync1_d    = {key2, key1, key0};
      sync2_d    = sync1_q;
      deb_d      = deb_q;
      deb_prev_d = deb_q;
      armed_d    = armed_q;
      ev_d       = '0;
      cnt_d      = '0;
      vld_d      = {vld_q[0], 1'b1};
      for (int k = 0; k < NK; k++) begin
         if (sync2_q[k] != deb_q[k]) begin
            if (cnt_q[k] == DBW'(DEBOUNCE_CYCLES - 1)) begin
               deb_d[k] = ~deb_q[k];
            end else begin
               cnt_d[k] = DBW'(cnt_q[k] + 1'b1);
            end
         end
         if (vld_q[1] && sync2_q[k]) begin
            armed_d[k] = 1'b1;
         end
         ev_d[k] = armed_q[k] & deb_prev_q[k] & ~deb_q[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= '1;
         sync2_q    <= '1;
         deb_q      <= '1;
         deb_prev_q <= '1;
         armed_q    <= '0;
         ev_q       <= '0;
         cnt_q      <= '0;
         vld_q      <= '0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         deb_q      <= deb_d;
         deb_prev_q <= deb_prev_d;
         armed_q    <= armed_d;
         ev_q       <= ev_d;
         cnt_q      <= cnt_d;
         vld_q      <= vld_d;
      end
   end

   // Sequencer: key0 > key1 > key2, lower-priority simultaneous events are dropped.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      led_d   = led_q;
      err_d   = err_q;
      ecnt_d  = ecnt_q;
      illegal = 1'b0;

      if (err_q) begin
         if (ecnt_q == '0) begin
            err_d = 1'b0;
         end else begin
            ecnt_d = ERW'(ecnt_q - 1'b1);
         end
      end

      if (ev_q[0]) begin
         a_d     = i_switch;
         led_d   = {1'b0, i_switch};
         state_d = ST_HAVE_A;
         if (state_q == ST_HAVE_B || state_q == ST_SHOW) begin
            b_d = '0;
         end
      end else if (ev_q[1]) begin
         case (state_q)
            ST_HAVE_A, ST_HAVE_B: begin
               b_d     = i_switch;
               led_d   = {1'b0, i_switch};
               state_d = ST_HAVE_B;
            end
            default: illegal = 1'b1;
         endcase
      end else if (ev_q[2]) begin
         case (state_q)
            ST_HAVE_B, ST_SHOW: begin
               led_d   = LW'(a_q) + LW'(b_q);
               state_d = ST_SHOW;
            end
            default: illegal = 1'b1;
         endcase
      end

      if (illegal) begin
         err_d  = 1'b1;
         ecnt_d = ERW'(ERR_CYCLES - 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         led_q   <= '0;
         err_q   <= 1'b0;
         ecnt_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         led_q   <= led_d;
         err_q   <= err_d;
         ecnt_q  <= ecnt_d;
      end
   end

   assign o_LED   = led_q;
   assign o_state = state_q;
   assign o_err   = err_q;

endmodule
